// File: rtl/prog_delay_line_mc_pkg.sv
// -----------------------------------------------------------------------------
// prog_delay_pkg
//   Shared definitions for the multi-channel programmable delay line:
//   default lane count and buffer depth, a constant-evaluable clog2 helper,
//   and the configuration request record {chan, delay}.
// -----------------------------------------------------------------------------
package prog_delay_pkg;

  localparam int DEF_CHANNELS = 4;
  localparam int DEF_DEPTH    = 16;

  // Width of each field in the config request record. Lane and delay codes
  // are zero-extended into it so out-of-range lane numbers stay comparable.
  localparam int CFG_FIELD_W  = 8;

  typedef struct packed {
    logic [CFG_FIELD_W-1:0] chan;
    logic [CFG_FIELD_W-1:0] delay;
  } cfg_req_t;

  // Ceiling log2, usable in parameter defaults. clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result++;
      rem = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/prog_delay_line_mc_if.sv
// -----------------------------------------------------------------------------
// prog_delay_line_mc_if
//   Valid/ready configuration port of the delay line.
//   cfg_valid  master->slave  request present
//   cfg_ready  slave->master  request accepted when valid && ready at an edge
//   cfg_chan   master->slave  target lane
//   cfg_delay  master->slave  new delay code d for that lane
//   cfg_err    slave->master  one-cycle pulse: accepted lane was out of range
// -----------------------------------------------------------------------------
interface prog_delay_line_mc_if #(
  parameter int LOG2_CHANNELS = 2,
  parameter int LOG2_DEPTH    = 4
);
  logic                     cfg_valid;
  logic                     cfg_ready;
  logic [LOG2_CHANNELS-1:0] cfg_chan;
  logic [LOG2_DEPTH-1:0]    cfg_delay;
  logic                     cfg_err;

  modport master (output cfg_valid, cfg_chan, cfg_delay,
                  input  cfg_ready, cfg_err);
  modport slave  (input  cfg_valid, cfg_chan, cfg_delay,
                  output cfg_ready, cfg_err);
endinterface

// File: rtl/prog_delay_line_mc_delay_tap_channel.sv
// -----------------------------------------------------------------------------
// delay_tap_channel
//   One lane of the delay line: circular buffer, read mux, per-lane delay
//   register d and glitch hold-off counter. Write pointer and fill level are
//   shared from the top so every lane stays phase-aligned.
//   clk, rst_n   clock, async active-low reset
//   din          lane input (written every cycle at wptr)
//   wptr, fill   shared write pointer / saturating fill count
//   cfg_we       load cfg_delay into d and restart hold-off
//   cfg_delay    new d
//   dout         registered lane output, latency d+1
//   dout_valid   output is genuine delayed data (buffer filled, not settling)
// -----------------------------------------------------------------------------
module delay_tap_channel
  import prog_delay_pkg::*;
#(
  parameter int WIDTH         = 1,
  parameter int DEPTH         = DEF_DEPTH,
  parameter int LOG2_DEPTH    = clog2(DEPTH),
  parameter int DEFAULT_DELAY = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      din,
  input  logic [LOG2_DEPTH-1:0] wptr,
  input  logic [LOG2_DEPTH-1:0] fill,
  input  logic                  cfg_we,
  input  logic [LOG2_DEPTH-1:0] cfg_delay,
  output logic [WIDTH-1:0]      dout,
  output logic                  dout_valid
);

  // Hold-off must hold up to DEPTH (d max + 1).
  localparam int HOLD_W = clog2(DEPTH + 1);
  localparam logic [LOG2_DEPTH:0] DEPTH_EXT = (LOG2_DEPTH+1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [LOG2_DEPTH-1:0] d;
  logic [HOLD_W-1:0]     holdoff;
  logic [LOG2_DEPTH:0]   rd_sum;
  logic [LOG2_DEPTH-1:0] rd_addr;

  // (wptr - d) mod DEPTH without relying on DEPTH being a power of two.
  assign rd_sum  = {1'b0, wptr} + DEPTH_EXT - {1'b0, d};
  assign rd_addr = (rd_sum >= DEPTH_EXT) ? LOG2_DEPTH'(rd_sum - DEPTH_EXT)
                                         : LOG2_DEPTH'(rd_sum);

  // NOTE: buffer storage has no reset; dout_valid masks stale entries until
  // the fill count covers the selected tap.
  always_ff @(posedge clk) begin
    mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d          <= LOG2_DEPTH'(DEFAULT_DELAY);
      holdoff    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      // At d = DEPTH-1 rd_addr equals the next write slot; the read here
      // returns the old entry because the write lands at the same edge.
      dout       <= (d == '0) ? din : mem[rd_addr];
      dout_valid <= (fill >= d) && (holdoff == '0);

      if (cfg_we) begin
        d       <= cfg_delay;
        holdoff <= HOLD_W'(cfg_delay) + HOLD_W'(1);
      end else if (holdoff != '0) begin
        holdoff <= holdoff - HOLD_W'(1);
      end
    end
  end

endmodule

// File: rtl/prog_delay_line_mc.sv
// -----------------------------------------------------------------------------
// prog_delay_line_mc
//   Multi-channel clocked programmable delay line. Lane ch of din is delayed
//   by 1+d[ch] cycles; d is programmed per lane over a valid/ready port.
//   CLOCK_50    single clock, rising edge
//   RESET_N     async active-low reset
//   din/dout    CHANNELS lanes of WIDTH bits, lane ch at [ch*WIDTH +: WIDTH]
//   dout_valid  per-lane genuine-data flag
//   cfg         config port (slave side): valid/ready/chan/delay/err
//   osc_en      oscillator request
//   Build option PROG_DELAY_OSC_EN: when defined and osc_en=1, lane 0 bit 0
//   input is replaced by ~dout[0], forming a ring with period 2*(d0+1).
//   When undefined, osc_en is ignored.
// -----------------------------------------------------------------------------
module prog_delay_line_mc
  import prog_delay_pkg::*;
#(
  parameter int CHANNELS      = DEF_CHANNELS,
  parameter int LOG2_CHANNELS = clog2(CHANNELS),
  parameter int WIDTH         = 1,
  parameter int DEPTH         = DEF_DEPTH,
  parameter int LOG2_DEPTH    = clog2(DEPTH),
  parameter int DEFAULT_DELAY = 0
) (
  input  logic                      CLOCK_50,
  input  logic                      RESET_N,
  input  logic [CHANNELS*WIDTH-1:0] din,
  output logic [CHANNELS*WIDTH-1:0] dout,
  output logic [CHANNELS-1:0]       dout_valid,
  input  logic                      osc_en,
  prog_delay_line_mc_if.slave       cfg
);

  logic [LOG2_DEPTH-1:0]     wptr;
  logic [LOG2_DEPTH-1:0]     fill;
  logic [CHANNELS*WIDTH-1:0] din_eff;
  logic [CHANNELS-1:0]       lane_we;
  cfg_req_t                  req;
  logic                      accept;
  logic                      chan_ok;

  assign req.chan  = CFG_FIELD_W'(cfg.cfg_chan);
  assign req.delay = CFG_FIELD_W'(cfg.cfg_delay);
  assign accept    = cfg.cfg_valid && cfg.cfg_ready;
  assign chan_ok   = int'(req.chan) < CHANNELS;

  // NOTE: din_eff gets its full default before any override, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    din_eff = din;
`ifdef PROG_DELAY_OSC_EN
    if (osc_en) din_eff[0] = ~dout[0];
`endif
  end

`ifndef PROG_DELAY_OSC_EN
  logic osc_en_unused;
  assign osc_en_unused = osc_en;
`endif

  // NOTE: non-blocking assignments for all registered state, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      wptr          <= '0;
      fill          <= '0;
      cfg.cfg_ready <= 1'b1;
      cfg.cfg_err   <= 1'b0;
    end else begin
      wptr <= (wptr == LOG2_DEPTH'(DEPTH - 1)) ? '0 : wptr + LOG2_DEPTH'(1);
      if (fill != LOG2_DEPTH'(DEPTH - 1)) fill <= fill + LOG2_DEPTH'(1);
      // One idle cycle after every accept caps the config rate at 1 per 2.
      cfg.cfg_ready <= !accept;
      cfg.cfg_err   <= accept && !chan_ok;
    end
  end

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_lane
    assign lane_we[ch] = accept && chan_ok && (int'(req.chan) == ch);

    delay_tap_channel #(
      .WIDTH         (WIDTH),
      .DEPTH         (DEPTH),
      .LOG2_DEPTH    (LOG2_DEPTH),
      .DEFAULT_DELAY (DEFAULT_DELAY)
    ) u_lane (
      .clk        (CLOCK_50),
      .rst_n      (RESET_N),
      .din        (din_eff[ch*WIDTH +: WIDTH]),
      .wptr       (wptr),
      .fill       (fill),
      .cfg_we     (lane_we[ch]),
      .cfg_delay  (LOG2_DEPTH'(req.delay)),
      .dout       (dout[ch*WIDTH +: WIDTH]),
      .dout_valid (dout_valid[ch])
    );
  end

endmodule

// File: tb/tb_prog_delay_line_mc.sv
// -----------------------------------------------------------------------------
// tb_prog_delay_line_mc
//   Directed bench for prog_delay_line_mc (4 lanes x 1 bit, depth 16).
//   The lane-select port is one bit wider than needed so an out-of-range
//   lane number (5) can be presented.
// -----------------------------------------------------------------------------
module tb_prog_delay_line_mc;

  localparam int CH     = 4;
  localparam int LOG2_C = 3;
  localparam int DEPTH  = 16;
  localparam int LOG2_D = 4;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic [CH-1:0] din    = '0;
  logic          osc_en = 1'b0;
  logic [CH-1:0] dout;
  logic [CH-1:0] dout_valid;

  prog_delay_line_mc_if #(.LOG2_CHANNELS(LOG2_C), .LOG2_DEPTH(LOG2_D)) cfg_bus ();

  prog_delay_line_mc #(
    .CHANNELS(CH), .LOG2_CHANNELS(LOG2_C), .WIDTH(1),
    .DEPTH(DEPTH), .LOG2_DEPTH(LOG2_D), .DEFAULT_DELAY(0)
  ) dut (
    .CLOCK_50   (clk),
    .RESET_N    (rst_n),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .osc_en     (osc_en),
    .cfg        (cfg_bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int lane;
    int delay;
    int exp_lat;
  } lat_vec_t;

  lat_vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one rising edge; sample and drive 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    din   = '0;
    cfg_bus.cfg_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Present one request and return just after its accept edge.
  task automatic cfg_write(input int chan, input int delay);
    for (int i = 0; i < 4 && !cfg_bus.cfg_ready; i++) tick();
    check("cfg_ready_wait", 32'(cfg_bus.cfg_ready), 32'd1);
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_chan  = LOG2_C'(chan);
    cfg_bus.cfg_delay = LOG2_D'(delay);
    tick();
    cfg_bus.cfg_valid = 1'b0;
  endtask

  // Cycles from presenting a one-cycle pulse to seeing it on dout (0 = never).
  task automatic pulse_latency(input int lane, output int lat);
    lat = 0;
    din[lane] = 1'b1;
    for (int n = 1; n <= DEPTH + 4; n++) begin
      tick();
      din[lane] = 1'b0;
      if (dout[lane]) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int cnt;
    int last;
    logic prev;

    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_chan  = '0;
    cfg_bus.cfg_delay = '0;

    vecs[0] = '{lane: 0, delay: 0,  exp_lat: 1};
    vecs[1] = '{lane: 1, delay: 7,  exp_lat: 8};
    vecs[2] = '{lane: 2, delay: 15, exp_lat: 16};
    vecs[3] = '{lane: 3, delay: 1,  exp_lat: 2};
    vecs[4] = '{lane: 0, delay: 4,  exp_lat: 5};
    vecs[5] = '{lane: 3, delay: 14, exp_lat: 15};

    // Reset state
    tick();
    tick();
    check("rst_dout",  32'(dout), 32'h0);
    check("rst_valid", 32'(dout_valid), 32'h0);
    check("rst_ready", 32'(cfg_bus.cfg_ready), 32'd1);
    check("rst_err",   32'(cfg_bus.cfg_err), 32'd0);
    rst_n = 1'b1;
    tick();
    check("valid_first_edge", 32'(dout_valid), 32'hF);

    // d=0: one-cycle pulse comes out one cycle later, one cycle wide
    repeat (3) tick();
    din[0] = 1'b1;
    tick();
    check("d0_pulse_hi", 32'(dout), 32'h1);
    din[0] = 1'b0;
    tick();
    check("d0_pulse_lo", 32'(dout), 32'h0);

    // Lane 1 d=7: valid low for 8 cycles after accept, then latency 8
    cfg_write(1, 7);
    for (int k = 1; k <= 9; k++) begin
      tick();
      check($sformatf("holdoff_l1_k%0d", k), 32'(dout_valid), (k <= 8) ? 32'hD : 32'hF);
    end
    pulse_latency(1, lat);
    check("lat_l1_d7", 32'(lat), 32'd8);

    // Reset then lane 2 d=15 at the first edge: valid[2] low through edge 17
    do_reset();
    cfg_write(2, 15);
    for (int k = 2; k <= 18; k++) begin
      tick();
      check($sformatf("fill_l2_k%0d", k), 32'(dout_valid[2]), (k >= 18) ? 32'd1 : 32'd0);
    end
    pulse_latency(2, lat);
    check("lat_l2_d15", 32'(lat), 32'd16);

    // Table: reset, program one lane, settle, measure pulse latency
    foreach (vecs[i]) begin
      do_reset();
      cfg_write(vecs[i].lane, vecs[i].delay);
      repeat (vecs[i].delay + 3) tick();
      check($sformatf("vec%0d_valid", i), 32'(dout_valid[vecs[i].lane]), 32'd1);
      pulse_latency(vecs[i].lane, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      tick();
      check($sformatf("vec%0d_width", i), 32'(dout[vecs[i].lane]), 32'd0);
    end

    // Continuous cfg_valid: accepts every other cycle
    do_reset();
    tick();
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_chan  = 3'd3;
    cfg_bus.cfg_delay = 4'd2;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ready_seq_%0d", i), 32'(cfg_bus.cfg_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      tick();
    end
    cfg_bus.cfg_valid = 1'b0;
    check("ready_seq_err", 32'(cfg_bus.cfg_err), 32'd0);

    // Out-of-range lane: err pulse only, no lane disturbed
    repeat (20) tick();
    check("oor_valid_before", 32'(dout_valid), 32'hF);
    cfg_write(5, 9);
    check("oor_err_hi", 32'(cfg_bus.cfg_err), 32'd1);
    tick();
    check("oor_err_lo", 32'(cfg_bus.cfg_err), 32'd0);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("oor_valid_%0d", k), 32'(dout_valid), 32'hF);
      tick();
    end
    pulse_latency(1, lat);
    check("oor_lat_l1", 32'(lat), 32'd1);
    pulse_latency(3, lat);
    check("oor_lat_l3", 32'(lat), 32'd3);

    // Oscillator request with d0=3
    cfg_write(0, 3);
    repeat (8) tick();
    din    = '0;
    osc_en = 1'b1;
`ifdef PROG_DELAY_OSC_EN
    prev = dout[0];
    last = 0;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (dout[0] != prev) begin
        last = n;
        break;
      end
    end
    check("osc_started", 32'(last != 0), 32'd1);
    for (int t = 0; t < 3; t++) begin
      prev = dout[0];
      cnt  = 0;
      for (int n = 1; n <= 12; n++) begin
        tick();
        if (dout[0] != prev) begin
          cnt = n;
          break;
        end
      end
      check($sformatf("osc_half_period_%0d", t), 32'(cnt), 32'd4);
    end
`else
    cnt = 0;
    for (int n = 0; n < 16; n++) begin
      tick();
      if (dout[0]) cnt++;
    end
    check("osc_ignored", 32'(cnt), 32'd0);
    pulse_latency(0, lat);
    check("osc_ignored_lat", 32'(lat), 32'd4);
`endif

    // Asynchronous reset mid-cycle clears outputs immediately
    din = 4'b1110;
    repeat (20) tick();
    check("pre_reset_dout", 32'(dout[3:1]), 32'h7);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_dout",  32'(dout), 32'h0);
    check("async_rst_valid", 32'(dout_valid), 32'h0);
    check("async_rst_ready", 32'(cfg_bus.cfg_ready), 32'd1);
    check("async_rst_err",   32'(cfg_bus.cfg_err), 32'd0);
    osc_en = 1'b0;
    din    = '0;
    tick();
    rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
